// File: rtl/idu_dispatch_param_if.sv
// Dispatch bus between the fetch queue, the dispatch unit and the RS array.
// The master modport is the fetch/RS side; the slave modport is the dispatch unit.
interface idu_dispatch_param_if #(
  parameter int INS_PART_WID = 4,
  parameter int TAG_LEN      = 4,
  parameter int NUM_RS       = 8
);
  localparam int BUS_WID = 3*TAG_LEN + 2*INS_PART_WID;

  logic                    inst_1_valid;
  logic [INS_PART_WID-1:0] inst_1_type;
  logic [INS_PART_WID-1:0] inst_1_dest;
  logic [INS_PART_WID-1:0] inst_1_src0;
  logic [INS_PART_WID-1:0] inst_1_src1;
  logic                    inst_1_fetch;

  logic                    inst_2_valid;
  logic [INS_PART_WID-1:0] inst_2_type;
  logic [INS_PART_WID-1:0] inst_2_dest;
  logic [INS_PART_WID-1:0] inst_2_src0;
  logic [INS_PART_WID-1:0] inst_2_src1;
  logic                    inst_2_fetch;

  logic [BUS_WID-1:0]      instruction1;
  logic                    instruction1_valid;
  logic [BUS_WID-1:0]      instruction2;
  logic                    instruction2_valid;

  logic [NUM_RS-1:0]       rs_done;
  logic                    illegal_inst;

  modport master (
    output inst_1_valid, inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1,
    output inst_2_valid, inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1,
    output rs_done,
    input  inst_1_fetch, inst_2_fetch,
    input  instruction1, instruction1_valid, instruction2, instruction2_valid,
    input  illegal_inst
  );

  modport slave (
    input  inst_1_valid, inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1,
    input  inst_2_valid, inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1,
    input  rs_done,
    output inst_1_fetch, inst_2_fetch,
    output instruction1, instruction1_valid, instruction2, instruction2_valid,
    output illegal_inst
  );
endinterface

// File: rtl/idu_dispatch_param.sv
// Dual-issue Tomasulo dispatch: per-FU-type RS pools, register status renaming,
// intra-pair RAW forwarding and done bypass. Optional counters under DISPATCH_STATS_EN.
module idu_dispatch_param #(
  parameter int NUM_FU_TYPES = 4,
  parameter int RS_PER_TYPE  = 2,
  parameter int NUM_REG      = 16,
  parameter int INS_PART_WID = 4,
  parameter int TAG_LEN      = 4,
  parameter int STORE_TYPE   = 4
) (
  input  logic                clk,
  input  logic                rst,
  idu_dispatch_param_if.slave bus
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]         stat_dispatched,
  output logic [31:0]         stat_stalls
`endif
);

  localparam int NUM_RS = NUM_FU_TYPES * RS_PER_TYPE;

  typedef logic [TAG_LEN-1:0]      tag_t;
  typedef logic [INS_PART_WID-1:0] part_t;

  logic [NUM_RS-1:0] busy_q;
  tag_t              status_q   [NUM_REG];
  tag_t              status_clr [NUM_REG];
  tag_t              status_nxt [NUM_REG];

  logic              legal1, legal2;
  logic              acc1, acc2;
  logic              disp1, disp2;
  logic              wr1, wr2;
  int                rs1, rs2;
  logic [NUM_RS-1:0] alloc1, alloc2;
  tag_t              tag1, tag2;
  tag_t              q10, q11, q20, q21;

  function automatic logic is_legal(input part_t t);
    return (t != '0) && (int'(t) <= NUM_FU_TYPES);
  endfunction

  // Lowest free RS index in the opcode's pool, or -1 when the pool is full.
  function automatic int find_free(input logic [NUM_RS-1:0] mask, input part_t t);
    int base;
    find_free = -1;
    if (is_legal(t)) begin
      base = (int'(t) - 1) * RS_PER_TYPE;
      for (int i = RS_PER_TYPE - 1; i >= 0; i--) begin
        if (!mask[base + i]) find_free = base + i;
      end
    end
  endfunction

  // Status table as it would look once this cycle's completions are applied;
  // reading from it gives the same-cycle done bypass for free.
  always_comb begin : done_clear
    for (int r = 0; r < NUM_REG; r++) begin
      status_clr[r] = status_q[r];
      for (int k = 0; k < NUM_RS; k++) begin
        if (bus.rs_done[k] && (status_q[r] == tag_t'(k + 1))) status_clr[r] = '0;
      end
    end
  end

  always_comb begin : allocate
    // NOTE: every variable gets a default before any conditional write,
    // otherwise an incomplete path infers a latch.
    alloc1 = '0;
    alloc2 = '0;

    legal1 = is_legal(bus.inst_1_type);
    rs1    = find_free(busy_q, bus.inst_1_type);
    acc1   = bus.inst_1_valid && (!legal1 || (rs1 >= 0));
    disp1  = acc1 && legal1;
    for (int k = 0; k < NUM_RS; k++) begin
      if (disp1 && (rs1 == k)) alloc1[k] = 1'b1;
    end

    // Slot 2 only issues behind slot 1, and sees slot 1's RS already taken.
    legal2 = is_legal(bus.inst_2_type);
    rs2    = find_free(busy_q | alloc1, bus.inst_2_type);
    acc2   = acc1 && bus.inst_2_valid && (!legal2 || (rs2 >= 0));
    disp2  = acc2 && legal2;
    for (int k = 0; k < NUM_RS; k++) begin
      if (disp2 && (rs2 == k)) alloc2[k] = 1'b1;
    end

    tag1 = disp1 ? tag_t'(rs1 + 1) : '0;
    tag2 = disp2 ? tag_t'(rs2 + 1) : '0;
    wr1  = disp1 && (bus.inst_1_type != part_t'(STORE_TYPE));
    wr2  = disp2 && (bus.inst_2_type != part_t'(STORE_TYPE));
  end

  always_comb begin : rename
    q10 = status_clr[bus.inst_1_src0];
    q11 = status_clr[bus.inst_1_src1];
    q20 = (wr1 && (bus.inst_2_src0 == bus.inst_1_dest)) ? tag1 : status_clr[bus.inst_2_src0];
    q21 = (wr1 && (bus.inst_2_src1 == bus.inst_1_dest)) ? tag1 : status_clr[bus.inst_2_src1];
  end

  // Slot 2 written last so it wins a WAW inside the pair; both win over done clears.
  always_comb begin : status_next
    for (int r = 0; r < NUM_REG; r++) status_nxt[r] = status_clr[r];
    if (wr1) status_nxt[bus.inst_1_dest] = tag1;
    if (wr2) status_nxt[bus.inst_2_dest] = tag2;
  end

  assign bus.inst_1_fetch = acc1;
  assign bus.inst_2_fetch = acc2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q                 <= '0;
      // NOTE: the status table is a small flop array that must read as
      // "all in register file" after reset, so it is reset explicitly.
      for (int r = 0; r < NUM_REG; r++) status_q[r] <= '0;
      bus.instruction1       <= '0;
      bus.instruction2       <= '0;
      bus.instruction1_valid <= 1'b0;
      bus.instruction2_valid <= 1'b0;
      bus.illegal_inst       <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~bus.rs_done) | alloc1 | alloc2;
      for (int r = 0; r < NUM_REG; r++) status_q[r] <= status_nxt[r];

      bus.instruction1_valid <= disp1;
      bus.instruction2_valid <= disp2;
      if (disp1) bus.instruction1 <= {tag1, q10, q11, bus.inst_1_src0, bus.inst_1_src1};
      if (disp2) bus.instruction2 <= {tag2, q20, q21, bus.inst_2_src0, bus.inst_2_src1};
      bus.illegal_inst <= (acc1 && !legal1) || (acc2 && !legal2);
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [32:0] disp_sum;

  always_comb disp_sum = {1'b0, stat_dispatched} + 33'(disp1) + 33'(disp2);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dispatched <= '0;
      stat_stalls     <= '0;
    end else begin
      stat_dispatched <= disp_sum[32] ? '1 : disp_sum[31:0];
      if (bus.inst_1_valid && !acc1 && (stat_stalls != '1))
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idu_dispatch_param.sv
// Self-checking bench for idu_dispatch_param: reference model predicts fetch and
// bus outputs; expected bus state is queued at drive time and compared after the edge.
module tb_idu_dispatch_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  idu_dispatch_param_if #(.INS_PART_WID(4), .TAG_LEN(4), .NUM_RS(8)) bus_if ();

`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_dispatched, stat_stalls;
`endif

  idu_dispatch_param dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_dispatched (stat_dispatched),
    .stat_stalls     (stat_stalls)
`endif
  );

  typedef struct packed {
    logic        v1;
    logic [19:0] d1;
    logic        v2;
    logic [19:0] d2;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  bit          m_busy [8];
  int          m_stat [16];
  logic [19:0] m_d1, m_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rd(input int r, input logic [7:0] done);
    int t = m_stat[r];
    if (t != 0 && done[t-1]) t = 0;
    return t;
  endfunction

  function automatic logic [7:0] busy_mask();
    logic [7:0] m = '0;
    for (int k = 0; k < 8; k++) m[k] = m_busy[k];
    return m;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("bus1_valid", bus_if.instruction1_valid, e.v1);
    check("bus1_data",  bus_if.instruction1,       e.d1);
    check("bus2_valid", bus_if.instruction2_valid, e.v2);
    check("bus2_data",  bus_if.instruction2,       e.d2);
    check("illegal",    bus_if.illegal_inst,       e.ill);
  endtask

  task automatic step(input bit v1, input int t1, input int d1, input int a1, input int b1,
                      input bit v2, input int t2, input int d2, input int a2, input int b2,
                      input logic [7:0] done);
    int r1, r2, tg1, tg2, q10, q11, q20, q21, idx;
    bit l1, l2, acc1, acc2, dp1, dp2;
    exp_t e;

    bus_if.inst_1_valid = v1;
    bus_if.inst_1_type  = 4'(t1);
    bus_if.inst_1_dest  = 4'(d1);
    bus_if.inst_1_src0  = 4'(a1);
    bus_if.inst_1_src1  = 4'(b1);
    bus_if.inst_2_valid = v2;
    bus_if.inst_2_type  = 4'(t2);
    bus_if.inst_2_dest  = 4'(d2);
    bus_if.inst_2_src0  = 4'(a2);
    bus_if.inst_2_src1  = 4'(b2);
    bus_if.rs_done      = done;

    l1 = (t1 >= 1 && t1 <= 4);
    r1 = -1;
    if (l1) for (int i = 0; i < 2; i++) begin
      idx = (t1 - 1) * 2 + i;
      if (r1 < 0 && !m_busy[idx]) r1 = idx;
    end
    acc1 = v1 && (!l1 || r1 >= 0);
    dp1  = acc1 && l1;
    tg1  = dp1 ? r1 + 1 : 0;

    l2 = (t2 >= 1 && t2 <= 4);
    r2 = -1;
    if (l2) for (int i = 0; i < 2; i++) begin
      idx = (t2 - 1) * 2 + i;
      if (r2 < 0 && !m_busy[idx] && !(dp1 && idx == r1)) r2 = idx;
    end
    acc2 = acc1 && v2 && (!l2 || r2 >= 0);
    dp2  = acc2 && l2;
    tg2  = dp2 ? r2 + 1 : 0;

    q10 = rd(a1, done);
    q11 = rd(b1, done);
    q20 = (dp1 && t1 != 4 && a2 == d1) ? tg1 : rd(a2, done);
    q21 = (dp1 && t1 != 4 && b2 == d1) ? tg1 : rd(b2, done);

    @(negedge clk);
    check("fetch1", bus_if.inst_1_fetch, acc1);
    check("fetch2", bus_if.inst_2_fetch, acc2);

    if (dp1) m_d1 = {4'(tg1), 4'(q10), 4'(q11), 4'(a1), 4'(b1)};
    if (dp2) m_d2 = {4'(tg2), 4'(q20), 4'(q21), 4'(a2), 4'(b2)};
    e.v1  = dp1;
    e.d1  = m_d1;
    e.v2  = dp2;
    e.d2  = m_d2;
    e.ill = (acc1 && !l1) || (acc2 && !l2);
    sb.push_back(e);

    for (int k = 0; k < 8; k++) if (done[k]) m_busy[k] = 1'b0;
    for (int r = 0; r < 16; r++) if (m_stat[r] != 0 && done[m_stat[r]-1]) m_stat[r] = 0;
    if (dp1) m_busy[r1] = 1'b1;
    if (dp2) m_busy[r2] = 1'b1;
    if (dp1 && t1 != 4) m_stat[d1] = tg1;
    if (dp2 && t2 != 4) m_stat[d2] = tg2;

    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // Inputs are left as they are, so a reset can land on a dispatching pair.
  task automatic reset_cycle();
    exp_t e;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) m_busy[k] = 1'b0;
    for (int r = 0; r < 16; r++) m_stat[r] = 0;
    m_d1 = '0;
    m_d2 = '0;
    e = '0;
    sb.push_back(e);
    compare_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] dn;
    bus_if.rs_done = '0;
    idle();
    reset_cycle();

    // ADD r1 <- r2, r3: tag 1, both sources in the register file.
    step(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, 8'h00);
    check("t1_tag", bus_if.instruction1[19:16], 1);
    check("t1_q",   bus_if.instruction1[15:8],  0);
    // Read r1 back: it now points at tag 1.
    step(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    check("t1_status", bus_if.instruction1[15:12], 1);

    // Pair with RAW: ADD r1 ; MULT r4 <- r1, r5.
    reset_cycle();
    step(1, 1, 1, 2, 3, 1, 2, 4, 1, 5, 8'h00);
    check("t2_tag",  bus_if.instruction2[19:16], 3);
    check("t2_fwd",  bus_if.instruction2[15:12], 1);
    check("t2_q1",   bus_if.instruction2[11:8],  0);

    // ADD pool exhaustion; a done frees the RS only from the next cycle.
    reset_cycle();
    step(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, 8'h00);
    step(1, 1, 2, 2, 3, 0, 0, 0, 0, 0, 8'h00);
    step(1, 1, 3, 2, 3, 0, 0, 0, 0, 0, 8'h00);
    check("t3_stall_valid", bus_if.instruction1_valid, 0);
    step(1, 1, 3, 2, 3, 0, 0, 0, 0, 0, 8'h01);
    step(1, 1, 3, 2, 3, 0, 0, 0, 0, 0, 8'h00);
    check("t3_reuse_tag", bus_if.instruction1[19:16], 1);

    // Done bypass on a same-cycle read, then the cleared entry.
    reset_cycle();
    step(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, 8'h00);
    step(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, 8'h00);
    step(1, 2, 5, 1, 1, 0, 0, 0, 0, 0, 8'h02);
    check("t4_bypass", bus_if.instruction1[15:8], 0);
    step(1, 2, 6, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    check("t4_cleared", bus_if.instruction1[15:12], 0);

    // Illegal opcodes in slot 1 (0 and above range), legal ADD behind them.
    reset_cycle();
    step(1, 0, 1, 2, 3, 1, 1, 4, 5, 6, 8'h00);
    check("t5_illegal", bus_if.illegal_inst, 1);
    check("t5_bus1",    bus_if.instruction1_valid, 0);
    step(1, 5, 1, 2, 3, 1, 1, 7, 4, 1, 8'h00);
    idle();
    check("t5_pulse_end", bus_if.illegal_inst, 0);

    // Same-pool pair, in-order stall, WAW, and store without forwarding.
    reset_cycle();
    step(1, 1, 1, 2, 3, 1, 1, 2, 1, 4, 8'h00);
    step(1, 1, 3, 0, 0, 1, 2, 4, 0, 0, 8'h00);
    step(1, 2, 7, 0, 0, 1, 2, 7, 0, 0, 8'h00);
    step(1, 4, 9, 7, 1, 1, 3, 10, 9, 7, 8'h00);
    step(1, 3, 11, 7, 7, 0, 0, 0, 0, 0, 8'h00);

    // Reset while both slots are dispatching.
    step(1, 1, 1, 1, 2, 1, 2, 2, 1, 3, 8'h0f);
    step(1, 1, 5, 0, 0, 1, 4, 6, 5, 1, 8'h00);
    reset_cycle();
    check("t6_valid1", bus_if.instruction1_valid, 0);
    check("t6_valid2", bus_if.instruction2_valid, 0);
    step(1, 1, 8, 1, 2, 1, 1, 9, 5, 7, 8'h00);
    check("t6_tag_after", bus_if.instruction1[19:16], 1);

    // Random traffic; completions only for busy RS.
    for (int n = 0; n < 80; n++) begin
      dn = 8'($urandom) & busy_mask();
      step(1'($urandom), $urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), dn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
